// File: rtl/minbd_pkg.sv
// Shared constants for the MinBD router eject stage.
// Port indices, flit field offsets, mode codes and LFSR setup.
package minbd_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;

  localparam int FLIT_W_DEF    = 11;
  localparam int VALID_BIT_DEF = FLIT_W_DEF - 1;
  localparam int DIR_LSB_DEF   = 6;
  localparam int DIR_W         = 3;

  localparam logic [11:0] HOLD_CODES_DEF =
    {3'b001, 3'b000, 3'b011, 3'b010};

  localparam logic [2:0] MODE_DISABLE = 3'd5;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1, left shift, feedback into bit 0
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/minbd_sync_fifo.sv
// Side-buffer FIFO with first-word fall-through head.
// Push is refused when full, pop is refused when empty.
module minbd_sync_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset, pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking, wrapping modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (do_push && !do_pop): count <= count + CW'(1);
        (!do_push && do_pop): count <= count - CW'(1);
        default:              count <= count;
      endcase
    end
  end

endmodule

// File: rtl/minbd_eject_buffer.sv
// MinBD side-buffer eject stage: pulls at most one eligible flit
// per cycle out of the stream and queues it for re-injection.
module minbd_eject_buffer
  import minbd_pkg::*;
#(
  parameter int                  NPORTS       = 4,
  parameter int                  FLIT_W       = FLIT_W_DEF,
  parameter int                  DIR_LSB      = DIR_LSB_DEF,
  parameter logic [3*NPORTS-1:0] HOLD_CODES   = HOLD_CODES_DEF,
  parameter int                  DEPTH        = 4,
  parameter int                  SEL_MODE     = 0,
  parameter logic [2:0]          DISABLE_MODE = MODE_DISABLE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  mode,
  input  logic [NPORTS*FLIT_W-1:0]    in_flit,
  output logic [NPORTS*FLIT_W-1:0]    out_flit,
  output logic                        eject_valid,
  output logic [NPORTS-1:0]           eject_port,
  output logic                        sb_valid,
  output logic [FLIT_W-1:0]           sb_flit,
  input  logic                        sb_ready,
  output logic [$clog2(DEPTH+1)-1:0]  sb_count,
  output logic                        sb_full
);

  localparam int PW = $clog2(NPORTS);
  localparam int VB = FLIT_W - 1;

  logic [NPORTS-1:0]        elig;
  logic [NPORTS-1:0]        win_oh;
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            rr_nxt;
  logic [PW-1:0]            start;
  logic [PW-1:0]            win_idx;
  logic [PW:0]              scan;
  logic                     found;
  logic [7:0]               lfsr;
  logic                     en;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FLIT_W-1:0]        win_flit;
  logic [NPORTS*FLIT_W-1:0] nxt_flit;

  // A channel is ejectable when valid and not carrying its hold code
  always_comb begin
    elig = '0;
    for (int p = 0; p < NPORTS; p++) begin
      elig[p] = in_flit[p*FLIT_W + VB] &&
        (in_flit[p*FLIT_W + DIR_LSB +: 3] != HOLD_CODES[p*3 +: 3]);
    end
  end

  // Scan origin: round-robin pointer or pseudo-random LFSR residue
  always_comb begin
    if (SEL_MODE == 0) start = rr_ptr;
    else start = PW'(lfsr % 8'(NPORTS));
  end

  // First eligible channel scanning upward from the origin
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      scan = {1'b0, start} + (PW+1)'(i);
      if (scan >= (PW+1)'(NPORTS)) scan = scan - (PW+1)'(NPORTS);
      if (!found && elig[scan[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
  end

  assign en = (mode != DISABLE_MODE) && !fifo_full && |elig;
  assign win_oh = en ? (NPORTS'(1) << win_idx) : '0;
  assign win_flit = in_flit[win_idx*FLIT_W +: FLIT_W];
  assign rr_nxt = (win_idx == PW'(NPORTS-1)) ? '0
                                             : win_idx + PW'(1);

  // Forwarded stream with the ejected slot marked invalid
  always_comb begin
    nxt_flit = in_flit;
    for (int p = 0; p < NPORTS; p++) begin
      if (win_oh[p]) nxt_flit[p*FLIT_W + VB] = 1'b0;
    end
  end

  // Registered stream, eject report, arbiter pointer and LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flit    <= '0;
      eject_valid <= 1'b0;
      eject_port  <= '0;
      rr_ptr      <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      out_flit    <= nxt_flit;
      eject_valid <= en;
      eject_port  <= win_oh;
      lfsr        <= lfsr_next(lfsr);
      if (en) rr_ptr <= rr_nxt;
    end
  end

  assign pop      = sb_valid && sb_ready;
  assign sb_valid = !fifo_empty;
  assign sb_full  = fifo_full;

  minbd_sync_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (en),
    .din   (win_flit),
    .pop   (pop),
    .dout  (sb_flit),
    .count (sb_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
